// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-side front end of the register file. Merges the main-pipe writeback
//   and the long-latency (mul/div) result port onto the single rf write port.
//   The main pipe always wins the port; mul/div results wait in a small FIFO
//   and drain on idle cycles. A per-register pending scoreboard lets decode
//   stall on registers whose mul/div result has not yet been written.
//
// Handshake: a mul/div result transfers on a rising edge where
//   md_valid && md_ready. md_ready depends only on registered state, so a full
//   FIFO never accepts in the same cycle it pops. Results addressed to r0 are
//   accepted and discarded. The main pipe has no back-pressure; it is asked to
//   insert a bubble through stall_req.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   pipe_we, pipe_w, pipe_d  main-pipe writeback
//   md_valid, md_w, md_d     mul/div result input
//   md_ready                 FIFO can accept a result
//   issue_md, issue_w        decode issued a mul/div op to issue_w
//   RFWr, W, din             rf write port
//   pending                  bit r set: register r awaits a mul/div result
//   stall_req                ask the main pipe for a bubble next cycle
//   fifo_count               FIFO occupancy, 0..DEPTH

module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH),
    localparam int SW = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_w,
    input  logic [31:0]   pipe_d,
    input  logic          md_valid,
    input  logic [4:0]    md_w,
    input  logic [31:0]   md_d,
    output logic          md_ready,
    input  logic          issue_md,
    input  logic [4:0]    issue_w,
    output logic          RFWr,
    output logic [4:0]    W,
    output logic [31:0]   din,
    output logic [31:0]   pending,
    output logic          stall_req,
    output logic [CW-1:0] fifo_count
);

    logic [4:0]    fifo_w [DEPTH];
    logic [31:0]   fifo_d [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic [31:0]   pend_q;
    logic [31:0]   pend_next;

    logic pipe_wr;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // A write to r0 is architecturally a no-op, so it leaves the port free.
    assign pipe_wr = pipe_we && (pipe_w != 5'd0);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    assign md_ready  = !rst && !full;
    assign push      = md_valid && md_ready && (md_w != 5'd0);
    assign pop       = !rst && !pipe_wr && !empty;
    assign stall_req = !rst && (full || (starve == SW'(STARVE_MAX)));

    assign fifo_count = count;
    assign pending    = pend_q;

    always_comb begin
        RFWr = 1'b0;
        W    = 5'd0;
        din  = 32'd0;
        if (!rst) begin
            if (pipe_wr) begin
                RFWr = 1'b1;
                W    = pipe_w;
                din  = pipe_d;
            end else if (!empty) begin
                RFWr = 1'b1;
                W    = fifo_w[rd_ptr];
                din  = fifo_d[rd_ptr];
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue to r keeps it pending.
    always_comb begin
        pend_next = pend_q;
        if (pop) begin
            pend_next[fifo_w[rd_ptr]] = 1'b0;
        end
        if (issue_md && (issue_w != 5'd0)) begin
            pend_next[issue_w] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Payload storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_w[wr_ptr] <= md_w;
            fifo_d[wr_ptr] <= md_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            pend_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Counts cycles a waiting result was denied the port.
            if (empty || pop) begin
                starve <= '0;
            end else if (starve != SW'(STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
            pend_q <= pend_next;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter. Every expected rf write ({W, din}) is
//   pushed into exp_q when its stimulus is issued; an independent monitor pops
//   and compares on each negedge where RFWr is high. Status outputs are checked
//   against hand-computed constants from the stimulus process.

module tb_rf_wb_arbiter;

  localparam int EW = 37;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_w;
  logic [31:0] pipe_d;
  logic        md_valid;
  logic [4:0]  md_w;
  logic [31:0] md_d;
  logic        md_ready;
  logic        issue_md;
  logic [4:0]  issue_w;
  logic        RFWr;
  logic [4:0]  W;
  logic [31:0] din;
  logic [31:0] pending;
  logic        stall_req;
  logic [2:0]  fifo_count;

  logic [EW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_w     (pipe_w),
    .pipe_d     (pipe_d),
    .md_valid   (md_valid),
    .md_w       (md_w),
    .md_d       (md_d),
    .md_ready   (md_ready),
    .issue_md   (issue_md),
    .issue_w    (issue_w),
    .RFWr       (RFWr),
    .W          (W),
    .din        (din),
    .pending    (pending),
    .stall_req  (stall_req),
    .fifo_count (fifo_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we  = 1'b0;
    pipe_w   = 5'd0;
    pipe_d   = 32'd0;
    md_valid = 1'b0;
    md_w     = 5'd0;
    md_d     = 32'd0;
    issue_md = 1'b0;
    issue_w  = 5'd0;
  endtask

  task automatic pipe_write(input logic [4:0] r, input logic [31:0] d);
    pipe_we = 1'b1;
    pipe_w  = r;
    pipe_d  = d;
    exp_q.push_back({r, d});
  endtask

  task automatic md_push(input logic [4:0] r, input logic [31:0] d);
    md_valid = 1'b1;
    md_w     = r;
    md_d     = d;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && RFWr) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got W=%0d din=%h expected no write", W, din);
      end else begin
        e = exp_q.pop_front();
        if ({W, din} !== e) begin
          n_err++;
          $display("FAIL rf_write: got W=%0d din=%h expected W=%0d din=%h",
                   W, din, e[36:32], e[31:0]);
        end
      end
    end
    // Decode must never let a pipe write hit a register still awaiting mul/div.
    if (!rst && pipe_we && pipe_w != 5'd0) begin
      n_cmp++;
      if (pending[pipe_w] !== 1'b0) begin
        n_err++;
        $display("FAIL protocol: pipe write to r%0d got pending=%b expected 0",
                 pipe_w, pending[pipe_w]);
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // stimulus
  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    md_push(5'd3, 32'h3333);
    pipe_we = 1'b1;
    pipe_w  = 5'd5;
    pipe_d  = 32'h1111;

    // reset with inputs active
    repeat (2) begin
      @(negedge clk);
      check("rst_rfwr", {31'd0, RFWr}, 32'd0);
      check("rst_md_ready", {31'd0, md_ready}, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
    end
    tick();
    rst = 1'b0;
    idle();
    check("rst_pending", pending, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    check("post_rst_md_ready", {31'd0, md_ready}, 32'd1);

    // main-pipe write goes straight through
    tick();
    pipe_write(5'd5, 32'hDEADBEEF);
    tick();
    idle();

    // issue, late result, scoreboard clear
    issue_md = 1'b1;
    issue_w  = 5'd9;
    tick();
    idle();
    check("pend9_set", {31'd0, pending[9]}, 32'd1);
    tick();
    tick();
    md_push(5'd9, 32'h1234);
    exp_q.push_back({5'd9, 32'h1234});
    @(negedge clk);
    check("md_ready_empty", {31'd0, md_ready}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("pend9_during_pop", {31'd0, pending[9]}, 32'd1);
    tick();
    check("pend9_clear", {31'd0, pending[9]}, 32'd0);
    check("count_after_pop", {29'd0, fifo_count}, 32'd0);

    // fill FIFO while the pipe owns the port
    for (int i = 0; i < 4; i++) begin
      tick();
      pipe_write(5'd20, 32'hA0 + i);
      md_push(5'(i + 1), 32'h100 + i);
      @(negedge clk);
      check("fill_md_ready", {31'd0, md_ready}, 32'd1);
      check("fill_stall", {31'd0, stall_req}, 32'd0);
    end
    tick();
    idle();
    md_push(5'd15, 32'hBAD);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(i + 1), 32'h100 + i});
    check("full_count", {29'd0, fifo_count}, 32'd4);
    @(negedge clk);
    check("full_md_ready", {31'd0, md_ready}, 32'd0);
    check("full_stall", {31'd0, stall_req}, 32'd1);
    tick();
    idle();
    check("drain_count", {29'd0, fifo_count}, 32'd3);
    @(negedge clk);
    check("drain_stall", {31'd0, stall_req}, 32'd0);
    tick();
    tick();
    tick();
    check("drained_count", {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    check("drained_stall", {31'd0, stall_req}, 32'd0);

    // starvation of a single entry
    tick();
    pipe_write(5'd21, 32'h5000);
    md_push(5'd11, 32'h55);
    for (int k = 1; k <= 3; k++) begin
      tick();
      md_valid = 1'b0;
      pipe_write(5'd21, 32'h5000 + k);
      check("starve_count", {29'd0, fifo_count}, 32'd1);
      @(negedge clk);
      check("starve_no_stall", {31'd0, stall_req}, 32'd0);
    end
    tick();
    idle();
    exp_q.push_back({5'd11, 32'h55});
    @(negedge clk);
    check("starve_stall", {31'd0, stall_req}, 32'd1);
    tick();
    check("starve_drained", {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    check("starve_cleared", {31'd0, stall_req}, 32'd0);

    // r0 result discarded
    tick();
    md_push(5'd0, 32'hFFFF);
    tick();
    idle();
    check("r0_count", {29'd0, fifo_count}, 32'd0);

    // same-cycle clear and set on r7
    tick();
    issue_md = 1'b1;
    issue_w  = 5'd7;
    pipe_write(5'd22, 32'h6000);
    md_push(5'd7, 32'h77);
    tick();
    idle();
    issue_md = 1'b1;
    issue_w  = 5'd7;
    exp_q.push_back({5'd7, 32'h77});
    check("pend7_before", {31'd0, pending[7]}, 32'd1);
    tick();
    idle();
    issue_md = 1'b1;
    issue_w  = 5'd0;
    check("pend7_set_wins", {31'd0, pending[7]}, 32'd1);
    check("pend7_count", {29'd0, fifo_count}, 32'd0);
    tick();
    idle();
    check("pend_vector", pending, 32'h0000_0080);

    // reset mid-operation drops queued results
    tick();
    issue_md = 1'b1;
    issue_w  = 5'd13;
    pipe_write(5'd23, 32'h7000);
    md_push(5'd13, 32'hD);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rfwr", {31'd0, RFWr}, 32'd0);
    tick();
    rst = 1'b0;
    check("midrst_pending", pending, 32'd0);
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    tick();
    tick();
    check("exp_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
